// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Memory stage of the pipeline. Turns EX/MEM fields into a
//               multi-cycle data-memory request, stalls upstream while it is in
//               flight and emits one registered writeback result per instruction.
//               Optional build macro MEM_ALIGN_CHECK_EN rejects odd addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_mem_to_reg,
    input  logic          ex_mem_write,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] ex_B,
    input  logic          ex_reg_write,
    input  logic [2:0]    ex_reg_wr_sel,
    input  logic          ex_dump,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_stall,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_out,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic          wb_reg_write,
    output logic [2:0]    wb_reg_wr_sel,
    output logic          wb_dump,
    output logic          err_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNTW-1:0] c_CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] c_CNT_ONE  = CNTW'(1);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [CNTW-1:0] r_cnt;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_wr;
    logic            r_err;
    logic            r_reg_write;
    logic [2:0]      r_reg_wr_sel;
    logic            r_dump;

    logic            r_wb_valid;
    logic [DW-1:0]   r_wb_data;
    logic            r_wb_reg_write;
    logic [2:0]      r_wb_reg_wr_sel;
    logic            r_wb_dump;
    logic            r_err_out;

    logic            w_access;
    logic            w_misalign;
    logic            w_fin;
    logic            w_fin_err;
    logic [DW-1:0]   w_fin_data;
    logic            w_pass;
    logic            w_stall;
    logic            w_mem_en;

    assign w_access = ex_valid & (ex_mem_to_reg | ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ex_result[0];
`else
    assign w_misalign = 1'b0;
`endif

    // w_fin marks the transition into DONE; the writeback registers load on it
    always_comb begin
        w_next     = r_state;
        w_fin      = 1'b0;
        w_fin_err  = r_err;
        w_fin_data = '0;
        w_pass     = 1'b0;
        w_stall    = 1'b0;
        w_mem_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_access;
                if (w_access) begin
                    if (w_misalign) begin
                        w_next    = S_DONE;
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end else begin
                        w_next = S_REQ;
                    end
                end else if (ex_valid) begin
                    w_pass = 1'b1;
                end
            end
            S_REQ: begin
                w_mem_en = 1'b1;
                w_stall  = 1'b1;
                if (!mem_stall) begin
                    if (mem_done) begin
                        w_next     = S_DONE;
                        w_fin      = 1'b1;
                        w_fin_data = r_wr ? r_addr : mem_rdata;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (mem_done) begin
                    w_next     = S_DONE;
                    w_fin      = 1'b1;
                    w_fin_data = r_wr ? r_addr : mem_rdata;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next    = S_DONE;
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wr            <= 1'b0;
            r_err           <= 1'b0;
            r_reg_write     <= 1'b0;
            r_reg_wr_sel    <= '0;
            r_dump          <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_data       <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_reg_wr_sel <= '0;
            r_wb_dump       <= 1'b0;
            r_err_out       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_access) begin
                r_addr       <= ex_result;
                r_wdata      <= ex_B;
                r_wr         <= ex_mem_write;
                r_err        <= ex_mem_to_reg & ex_mem_write;
                r_reg_write  <= ex_reg_write;
                r_reg_wr_sel <= ex_reg_wr_sel;
                r_dump       <= ex_dump;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else begin
                r_cnt <= '0;
            end
            r_wb_valid <= w_fin | w_pass;
            r_err_out  <= w_fin & w_fin_err;
            // Results leaving straight from IDLE take the live EX/MEM fields
            if (w_fin || w_pass) begin
                r_wb_data <= w_fin ? w_fin_data : ex_result;
                if (r_state == S_IDLE) begin
                    r_wb_reg_write  <= ex_reg_write;
                    r_wb_reg_wr_sel <= ex_reg_wr_sel;
                    r_wb_dump       <= ex_dump;
                end else begin
                    r_wb_reg_write  <= r_reg_write;
                    r_wb_reg_wr_sel <= r_reg_wr_sel;
                    r_wb_dump       <= r_dump;
                end
            end
        end
    end

    assign mem_en        = w_mem_en;
    assign mem_wr        = w_mem_en & r_wr;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign stall_out     = w_stall;
    assign wb_valid      = r_wb_valid;
    assign wb_data       = r_wb_data;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_reg_wr_sel = r_wb_reg_wr_sel;
    assign wb_dump       = r_wb_dump;
    assign err_out       = r_err_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl; expected writeback
//               results are queued at issue and compared when wb_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        logic          reg_write;
        logic [2:0]    sel;
        logic          dump;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_mem_to_reg = 1'b0;
    logic          ex_mem_write = 1'b0;
    logic [DW-1:0] ex_result = '0;
    logic [DW-1:0] ex_B = '0;
    logic          ex_reg_write = 1'b0;
    logic [2:0]    ex_reg_wr_sel = '0;
    logic          ex_dump = 1'b0;
    logic          mem_en;
    logic          mem_wr;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_stall = 1'b0;
    logic          mem_done = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_out;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic          wb_reg_write;
    logic [2:0]    wb_reg_wr_sel;
    logic          wb_dump;
    logic          err_out;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    mem_access_ctrl #(.DW(DW), .TIMEOUT(15), .CNTW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_write  (ex_mem_write),
        .ex_result     (ex_result),
        .ex_B          (ex_B),
        .ex_reg_write  (ex_reg_write),
        .ex_reg_wr_sel (ex_reg_wr_sel),
        .ex_dump       (ex_dump),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_stall     (mem_stall),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .stall_out     (stall_out),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_reg_write  (wb_reg_write),
        .wb_reg_wr_sel (wb_reg_wr_sel),
        .wb_dump       (wb_dump),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every wb_valid pulse must match the oldest queued result
    always @(negedge clk) begin
        if (rst && wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_result", {10'd0, wb_data, err_out, wb_reg_write, wb_reg_wr_sel, wb_dump},
                    {10'd0, e});
            end
        end
    end

    // Presents one instruction and plays the memory: stall_n cycles of mem_stall,
    // then mem_done done_dly cycles after the accepted mem_en (-1 = never).
    task automatic run_instr(input logic ld, input logic st, input logic [DW-1:0] res,
                             input logic [DW-1:0] b, input logic [DW-1:0] rdata,
                             input int stall_n, input int done_dly, input exp_t e,
                             input logic expect_wb,
                             output int n_st, output int n_en, output logic wr_seen,
                             output logic [DW-1:0] addr0, output logic [DW-1:0] wdata0,
                             output logic unstable);
        int  stall_left;
        int  since_en;
        bit  ok;
        n_st = 0; n_en = 0; wr_seen = 1'b0; addr0 = '0; wdata0 = '0; unstable = 1'b0;
        stall_left = stall_n; since_en = -1; ok = 1'b0;
        if (expect_wb) sb_q.push_back(e);
        ex_valid = 1'b1; ex_mem_to_reg = ld; ex_mem_write = st; ex_result = res; ex_B = b;
        ex_reg_write = e.reg_write; ex_reg_wr_sel = e.sel; ex_dump = e.dump;
        mem_rdata = rdata;
        for (int c = 0; c < 60; c++) begin
            mem_stall = 1'b0;
            mem_done  = 1'b0;
            if (mem_en) begin
                if (n_en == 0) begin
                    addr0 = mem_addr; wdata0 = mem_wdata; wr_seen = mem_wr;
                end else if (mem_addr !== addr0 || mem_wdata !== wdata0 || mem_wr !== wr_seen) begin
                    unstable = 1'b1;
                end
                n_en++;
                if (stall_left > 0) begin
                    mem_stall = 1'b1;
                    stall_left--;
                end else begin
                    since_en = 0;
                    if (done_dly == 0) mem_done = 1'b1;
                end
            end else if (since_en >= 0) begin
                since_en++;
                if (since_en == done_dly) mem_done = 1'b1;
            end
            #1;
            if (stall_out) n_st++;
            else ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        if (!ok) chk("instr_hang", {31'd0, stall_out}, 32'd0);
        ex_valid = 1'b0; ex_mem_to_reg = 1'b0; ex_mem_write = 1'b0;
        mem_stall = 1'b0; mem_done = 1'b0;
    endtask

    initial begin
        int            st, en;
        logic          wr, unst;
        logic [DW-1:0] a0, d0;

        // Reset state
        #2;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Pass-through
        run_instr(1'b0, 1'b0, 16'h1234, 16'h0, 16'h0, 0, 0, '{16'h1234, 1'b0, 1'b1, 3'd3, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("pass_stall", st, 0);
        chk("pass_mem_en", en, 0);
        @(negedge clk);
        chk("hold_valid", {31'd0, wb_valid}, 32'd0);
        chk("hold_data", {16'd0, wb_data}, 32'h1234);

        // Pass-through carrying dump marker
        run_instr(1'b0, 1'b0, 16'h00A5, 16'h0, 16'h0, 0, 0, '{16'h00A5, 1'b0, 1'b0, 3'd7, 1'b1},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("pass2_stall", st, 0);

        // Load completing two cycles after mem_en
        run_instr(1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 0, 2, '{16'hBEEF, 1'b0, 1'b1, 3'd5, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("ld_stall", st, 4);
        chk("ld_mem_en", en, 1);
        chk("ld_mem_wr", {31'd0, wr}, 32'd0);
        chk("ld_addr", {16'd0, a0}, 32'h0040);

        // Store with three stalled request cycles
        run_instr(1'b0, 1'b1, 16'h0100, 16'hCAFE, 16'h0, 3, 1, '{16'h0100, 1'b0, 1'b0, 3'd0, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("st_stall", st, 6);
        chk("st_mem_en", en, 4);
        chk("st_mem_wr", {31'd0, wr}, 32'd1);
        chk("st_addr", {16'd0, a0}, 32'h0100);
        chk("st_wdata", {16'd0, d0}, 32'hCAFE);
        chk("st_stable", {31'd0, unst}, 32'd0);

        // Load that never completes
        run_instr(1'b1, 1'b0, 16'h0080, 16'h0, 16'h1111, 0, -1, '{16'h0000, 1'b1, 1'b1, 3'd2, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("to_stall", st, 17);
        chk("to_mem_en", en, 1);
        #1;
        chk("to_idle_stall", {31'd0, stall_out}, 32'd0);
        chk("to_idle_mem_en", {31'd0, mem_en}, 32'd0);

        // Load and store both set: executed as a write, flagged as an error
        run_instr(1'b1, 1'b1, 16'h0200, 16'h7777, 16'h0, 0, 0, '{16'h0200, 1'b1, 1'b1, 3'd1, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("both_stall", st, 2);
        chk("both_mem_wr", {31'd0, wr}, 32'd1);

        // Reset asserted while a load sits in WAIT
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_to_reg = 1'b1; ex_result = 16'h0060; ex_reg_write = 1'b1;
        @(negedge clk);
        chk("rw_req_en", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        #2;
        ex_valid = 1'b0; ex_mem_to_reg = 1'b0;
        rst = 1'b0;
        #1;
        chk("rw_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rw_stall", {31'd0, stall_out}, 32'd0);
        chk("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_instr(1'b1, 1'b0, 16'h0062, 16'h0, 16'h4321, 0, 1, '{16'h4321, 1'b0, 1'b0, 3'd4, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("rw_after_stall", st, 3);
        chk("rw_after_addr", {16'd0, a0}, 32'h0062);

        // Odd address load
`ifdef MEM_ALIGN_CHECK_EN
        run_instr(1'b1, 1'b0, 16'h0041, 16'h0, 16'h5A5A, 0, 2, '{16'h0000, 1'b1, 1'b1, 3'd6, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("odd_stall", st, 1);
        chk("odd_mem_en", en, 0);
`else
        run_instr(1'b1, 1'b0, 16'h0041, 16'h0, 16'h5A5A, 0, 2, '{16'h5A5A, 1'b0, 1'b1, 3'd6, 1'b0},
                  1'b1, st, en, wr, a0, d0, unst);
        chk("odd_stall", st, 4);
        chk("odd_mem_en", en, 1);
        chk("odd_addr", {16'd0, a0}, 32'h0041);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
